lcd_power_seq: RTL

- Power/enable sequencer for the RGB LCD path.
- Drives panel reset, backlight PWM and the timing-generator enable (timing_en feeds the LCD driver's enable) in a fixed power-up/power-down order.
- Counts frames from the driver's lcd_vs.
- Sits beside the LCD driver in the top-level.

---
 rtl/lcd_seq_pkg.sv | 17 +
 rtl/lcd_bl_pwm.sv | 67 ++++++
 rtl/lcd_power_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/lcd_seq_pkg.sv
// Shared state encodings and widths for the LCD power sequencer.
package lcd_seq_pkg;

   localparam int SEQ_W  = 3;
   localparam int DUTY_W = 8;

   typedef enum logic [SEQ_W-1:0] {
      OFF        = 3'd0,
      RST_HOLD   = 3'd1,
      RST_WAIT   = 3'd2,
      TIMING_ON  = 3'd3,
      ON         = 3'd4,
      BL_OFF     = 3'd5,
      TIMING_OFF = 3'd6
   } seq_state_t;

endpackage

// File: rtl/lcd_bl_pwm.sv
// Backlight PWM: prescaler, free-running 8-bit counter and duty latch.
// Optional per-frame duty fade when LCD_BL_FADE_EN is defined.
module lcd_bl_pwm
   import lcd_seq_pkg::*;
#(
   parameter int PWM_DIV = 195
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              enable,
   input  logic [DUTY_W-1:0] target_duty,
   input  logic              frame_evt,
   output logic              lcd_bl,
   output logic              duty_is_zero
);

   localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PWM_DIV - 1);

   logic [PRE_W-1:0]  pre_cnt, pre_nxt;
   logic [DUTY_W-1:0] pwm_cnt, pwm_nxt;
   logic [DUTY_W-1:0] duty, duty_nxt;
   logic              enable_q;
   logic              step;

   always_comb begin
      step     = (pre_cnt == PRE_MAX);
      pre_nxt  = step ? '0 : pre_cnt + 1'b1;
      pwm_nxt  = step ? pwm_cnt + 1'b1 : pwm_cnt;
      duty_nxt = duty;
      // Duty is held at zero while disabled so duty_is_zero reads true outside ON.
      if (!enable) begin
         duty_nxt = '0;
`ifdef LCD_BL_FADE_EN
      end else if (!enable_q) begin
         duty_nxt = '0;
      end else if (frame_evt && (duty < target_duty)) begin
         duty_nxt = duty + 1'b1;
      end else if (frame_evt && (duty > target_duty)) begin
         duty_nxt = duty - 1'b1;
      end
`else
      end else if (!enable_q || (step && (pwm_cnt == '1))) begin
         duty_nxt = target_duty;
      end
`endif
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         pre_cnt  <= '0;
         pwm_cnt  <= '0;
         duty     <= '0;
         enable_q <= 1'b0;
         lcd_bl   <= 1'b0;
      end else begin
         pre_cnt  <= pre_nxt;
         pwm_cnt  <= pwm_nxt;
         duty     <= duty_nxt;
         enable_q <= enable;
         lcd_bl   <= enable && (pwm_nxt < duty_nxt);
      end
   end

   assign duty_is_zero = (duty == '0);

endmodule

// File: rtl/lcd_power_seq.sv
// Panel power/enable sequencer: reset, timing enable and backlight ordering.
// Optional backlight fade via LCD_BL_FADE_EN.
//
// state      | meaning
// OFF        | panel unpowered, waiting for panel_en
// RST_HOLD   | lcd_rst held low for T_RST_MS
// RST_WAIT   | reset released, panel init delay T_INIT_MS
// TIMING_ON  | video running, backlight off, waiting T_BL_FRAMES frames
// ON         | video and backlight PWM active
// BL_OFF     | backlight off, video kept for T_BL_FRAMES frames
// TIMING_OFF | timing stopped, settle T_OFF_MS before OFF
module lcd_power_seq
   import lcd_seq_pkg::*;
#(
   parameter int TICK_CYC    = 50000,
   parameter int T_RST_MS    = 10,
   parameter int T_INIT_MS   = 120,
   parameter int T_BL_FRAMES = 2,
   parameter int T_OFF_MS    = 20,
   parameter int FRAME_TO_MS = 100,
   parameter int PWM_DIV     = 195
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              panel_en,
   input  logic [DUTY_W-1:0] bl_duty,
   input  logic              lcd_vs,
   output logic              timing_en,
   output logic              lcd_rst,
   output logic              lcd_bl,
   output logic              panel_ready,
   output logic [SEQ_W-1:0]  seq_state
);

   localparam int TICK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam int MS_W   = 16;
   localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(TICK_CYC - 1);
   localparam logic [MS_W-1:0]   RST_LAST  = MS_W'(T_RST_MS - 1);
   localparam logic [MS_W-1:0]   INIT_LAST = MS_W'(T_INIT_MS - 1);
   localparam logic [MS_W-1:0]   OFF_LAST  = MS_W'(T_OFF_MS - 1);
   localparam logic [MS_W-1:0]   FTO_LAST  = MS_W'(FRAME_TO_MS - 1);
   localparam logic [7:0]        FRM_LAST  = 8'(T_BL_FRAMES - 1);

   seq_state_t        state, nxt;
   logic [TICK_W-1:0] presc;
   logic [MS_W-1:0]   ms_cnt;
   logic [7:0]        frm_cnt;
   logic              vs_q;
   logic              ms_tick, vs_fall, frame_win, frame_evt;
   logic              frm_count_en, frm_done;
   logic              bl_en, duty_is_zero;
   logic [DUTY_W-1:0] bl_target;

   always_comb begin
      ms_tick = (presc == '0);
      vs_fall = vs_q && !lcd_vs;
`ifdef LCD_BL_FADE_EN
      frame_win = (state == TIMING_ON) || (state == ON) || (state == BL_OFF);
`else
      frame_win = (state == TIMING_ON) || (state == BL_OFF);
`endif
      frame_evt    = frame_win && (vs_fall || (ms_tick && (ms_cnt == FTO_LAST)));
      // BL_OFF frames only count once the backlight has fully dimmed.
      frm_count_en = frame_evt && ((state != BL_OFF) || duty_is_zero);
      frm_done     = frm_count_en && (frm_cnt == FRM_LAST);

      nxt = state;
      case (state)
         OFF:        if (panel_en) nxt = RST_HOLD;
         RST_HOLD:   if (!panel_en) nxt = OFF;
                     else if (ms_tick && (ms_cnt == RST_LAST)) nxt = RST_WAIT;
         RST_WAIT:   if (!panel_en) nxt = OFF;
                     else if (ms_tick && (ms_cnt == INIT_LAST)) nxt = TIMING_ON;
         TIMING_ON:  if (!panel_en) nxt = TIMING_OFF;
                     else if (frm_done) nxt = ON;
         ON:         if (!panel_en) nxt = BL_OFF;
         BL_OFF:     if (frm_done) nxt = TIMING_OFF;
         TIMING_OFF: if (ms_tick && (ms_cnt == OFF_LAST)) nxt = OFF;
         default:    nxt = OFF;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state       <= OFF;
         presc       <= '0;
         ms_cnt      <= '0;
         frm_cnt     <= '0;
         vs_q        <= 1'b1;
         timing_en   <= 1'b0;
         lcd_rst     <= 1'b0;
         panel_ready <= 1'b0;
      end else begin
         state <= nxt;
         vs_q  <= lcd_vs;
         // Timebase restarts on entry and on every frame so dwell and timeout are exact.
         if ((nxt != state) || frame_evt) begin
            presc  <= TICK_LOAD;
            ms_cnt <= '0;
         end else if (ms_tick) begin
            presc  <= TICK_LOAD;
            ms_cnt <= ms_cnt + 1'b1;
         end else begin
            presc  <= presc - 1'b1;
         end
         if (nxt != state)      frm_cnt <= '0;
         else if (frm_count_en) frm_cnt <= frm_cnt + 1'b1;
         lcd_rst     <= (nxt != OFF) && (nxt != RST_HOLD);
         timing_en   <= (nxt == TIMING_ON) || (nxt == ON) || (nxt == BL_OFF);
         panel_ready <= (nxt == ON);
      end
   end

`ifdef LCD_BL_FADE_EN
   assign bl_en     = (nxt == ON) || (nxt == BL_OFF);
   assign bl_target = (state == BL_OFF) ? '0 : bl_duty;
`else
   assign bl_en     = (nxt == ON);
   assign bl_target = bl_duty;
`endif

   lcd_bl_pwm #(.PWM_DIV(PWM_DIV)) u_bl_pwm (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .enable       (bl_en),
      .target_duty  (bl_target),
      .frame_evt    (frame_evt),
      .lcd_bl       (lcd_bl),
      .duty_is_zero (duty_is_zero)
   );

   assign seq_state = state;

endmodule
